// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: decode opcodes, fetch FSM states and
// the instruction word type.
package riscv_pkg;

  localparam int INST_W = 32;

  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE    = 7'b0010011;
  localparam logic [6:0] LD_TYPE   = 7'b0000011;
  localparam logic [6:0] S_TYPE    = 7'b0100011;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] JAL_TYPE  = 7'b1101111;
  localparam logic [6:0] JALR_TYPE = 7'b1100111;
  localparam logic [6:0] LUI_TYPE  = 7'b0110111;
  localparam logic [6:0] AUI_TYPE  = 7'b0010111;
  localparam logic [6:0] HALT_TYPE = 7'b1111111;

  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALTED} fetch_state_t;

  typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time over
// req/ack, buffers it for decode over valid/ready, applies redirects, halts.
module instr_fetch_unit #(
  parameter int              PC_W     = 9,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   pc_plus4_o,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              halted_o
);
  import riscv_pkg::fetch_state_t;
  import riscv_pkg::IDLE;
  import riscv_pkg::FETCH;
  import riscv_pkg::VALID;
  import riscv_pkg::HALTED;
  import riscv_pkg::HALT_TYPE;

  fetch_state_t      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [PC_W-1:0]   pc_out_q;
  logic [INST_W-1:0] inst_q;
  logic              squash_q, squash_d;
  logic              capture;
  logic [PC_W-1:0]   redirect_tgt;
  logic [PC_W-1:0]   pc_seq;
  logic              is_halt;

  assign redirect_tgt = redirect_pc_i & ~PC_W'(3);
  assign pc_seq       = pc_q + PC_W'(4);
  assign is_halt      = (inst_q[6:0] == HALT_TYPE);

  // addr_q is the address of the outstanding request; pc_q may move ahead of
  // it on a redirect so the memory still sees a stable address until ack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    squash_d = squash_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        addr_d  = pc_q;
      end
      FETCH: begin
        if (imem_ack) begin
          if (squash_q || redirect_i) begin
            squash_d = 1'b0;
            if (redirect_i) begin
              pc_d   = redirect_tgt;
              addr_d = redirect_tgt;
            end else begin
              addr_d = pc_q;
            end
          end else begin
            capture = 1'b1;
            state_d = VALID;
          end
        end else if (redirect_i) begin
          pc_d     = redirect_tgt;
          squash_d = 1'b1;
        end
      end
      VALID: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          addr_d  = redirect_tgt;
          state_d = FETCH;
        end else if (inst_ready_i) begin
          if (is_halt) begin
            state_d = HALTED;
          end else begin
            pc_d    = pc_seq;
            addr_d  = pc_seq;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      squash_q <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      squash_q <= squash_d;
      if (capture) begin
        inst_q   <= imem_rdata;
        pc_out_q <= addr_q;
      end
    end
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = addr_q;
  assign inst_valid_o = (state_q == VALID);
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;
  assign pc_plus4_o   = pc_out_q + PC_W'(4);
  assign halted_o     = (state_q == HALTED);

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> $stable(imem_addr));

  a_inst_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (inst_valid_o && !inst_ready_i) |=> $stable(inst_o));

endmodule
